// File: rtl/polaris_uart_rx_os.sv
// rtl/polaris_uart_rx_os.sv - oversampled UART receiver with parity, framing and break detection
module polaris_uart_rx_os #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        lsioc_clk_i,
  input  logic        lsioc_rst_i,
  input  logic [11:0] clktobaudrate,
  input  logic        rx_en,
  input  logic        par_en_i,
  input  logic        par_odd_i,
  input  logic        uart_rx_i,
  output logic        rx_vld_o,
  output logic [7:0]  rx_byte_o,
  output logic        frame_err_o,
  output logic        par_err_o,
  output logic        break_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs_prev_q, rxs_prev_d;
  logic [11:0]            timer_q, timer_d;
  logic [11:0]            period_q, period_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   par_pend_q, par_pend_d;
  logic                   par_bit_q, par_bit_d;
  logic                   rx_vld_q, rx_vld_d;
  logic                   frame_err_q, frame_err_d;
  logic                   par_err_q, par_err_d;
  logic                   break_q, break_d;

  logic        rxs;
  logic [11:0] p_in;
  logic [11:0] timer_dec;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign p_in      = (clktobaudrate < 12'd4) ? 12'd4 : clktobaudrate;
  assign timer_dec = (timer_q != 12'd0) ? (timer_q - 12'd1) : 12'd0;

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], uart_rx_i};
    rxs_prev_d  = rxs;
    timer_d     = timer_q;
    period_d    = period_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    par_pend_d  = par_pend_q;
    par_bit_d   = par_bit_q;
    rx_vld_d    = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    break_d     = 1'b0;

    if (state_q != S_IDLE && state_q != S_WAIT_HIGH) begin
      timer_d = timer_dec;
    end

    case (state_q)
      S_IDLE: begin
        // Frame settings are captured here so mid-frame changes cannot corrupt the frame
        if (rx_en && rxs_prev_q && !rxs) begin
          state_d    = S_START;
          period_d   = p_in;
          timer_d    = (p_in >> 1) - 12'd1;
          par_en_d   = par_en_i;
          par_odd_d  = par_odd_i;
          par_pend_d = 1'b0;
          par_bit_d  = 1'b0;
          shift_d    = 8'h00;
        end
      end
      S_START: begin
        if (timer_q == 12'd0) begin
          if (!rxs) begin
            state_d = S_DATA;
            timer_d = period_q - 12'd1;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer_q == 12'd0) begin
          shift_d[idx_q] = rxs;
          timer_d        = period_q - 12'd1;
          if (idx_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (timer_q == 12'd0) begin
          par_pend_d = (^shift_q) ^ rxs ^ par_odd_q;
          par_bit_d  = rxs;
          timer_d    = period_q - 12'd1;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == 12'd0) begin
          rx_byte_d = shift_q;
          if (rxs) begin
            rx_vld_d  = 1'b1;
            par_err_d = par_pend_q;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            break_d     = (shift_q == 8'h00) && (!par_en_q || !par_bit_q);
            state_d     = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!rx_en) begin
      state_d     = S_IDLE;
      rx_byte_d   = rx_byte_q;
      rx_vld_d    = 1'b0;
      frame_err_d = 1'b0;
      par_err_d   = 1'b0;
      break_d     = 1'b0;
    end
  end

  always_ff @(posedge lsioc_clk_i) begin
    if (!lsioc_rst_i) begin
      state_q     <= S_IDLE;
      sync_q      <= '1;
      rxs_prev_q  <= 1'b1;
      timer_q     <= 12'd0;
      period_q    <= 12'd4;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      par_pend_q  <= 1'b0;
      par_bit_q   <= 1'b0;
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rxs_prev_q  <= rxs_prev_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      par_pend_q  <= par_pend_d;
      par_bit_q   <= par_bit_d;
      rx_vld_q    <= rx_vld_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      break_q     <= break_d;
    end
  end

  assign rx_vld_o    = rx_vld_q;
  assign rx_byte_o   = rx_byte_q;
  assign frame_err_o = frame_err_q;
  assign par_err_o   = par_err_q;
  assign break_o     = break_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
